// File: rtl/lcd_cmd_driver.sv
// lcd_cmd_driver: turns toggle-strobed LSU LCD register writes into timed HD44780 write cycles, with power-on init.
module lcd_cmd_driver #(
  parameter int POR_CYC   = 2_000_000,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 12,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2_000,
  parameter int CLR_CYC   = 80_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] io_lcd_i,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o,
  output logic        busy_o,
  output logic        init_done_o,
  output logic        ovf_o
);
  localparam int M1 = POR_CYC > CLR_CYC ? POR_CYC : CLR_CYC;
  localparam int M2 = M1 > EXEC_CYC ? M1 : EXEC_CYC;
  localparam int M3 = M2 > EN_CYC ? M2 : EN_CYC;
  localparam int M4 = M3 > SETUP_CYC ? M3 : SETUP_CYC;
  localparam int MAXC = M4 > HOLD_CYC ? M4 : HOLD_CYC;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {POR_WAIT, INIT, IDLE, SETUP, EN_HIGH, HOLD, WAIT} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] step, step_n;
  logic done_n, rs_n, slot_full, slot_full_n, slot_rs, slot_rs_n, last_tog, ovf_n;
  logic new_cmd, pop, clr;
  logic [7:0] data_n, slot_data, slot_data_n;
  logic unused;

  assign unused = ^io_lcd_i[29:9];
  assign lcd_rw_o = 1'b0;

  always_comb begin
    new_cmd = io_lcd_i[30] ^ last_tog;
    pop = (state == IDLE) && slot_full;
    clr = !lcd_rs_o && lcd_data_o[7:2] == 6'd0;
    state_n = state;
    step_n = step;
    done_n = init_done_o;
    rs_n = lcd_rs_o;
    data_n = lcd_data_o;
    case (state)
      POR_WAIT: state_n = (cnt == CW'(POR_CYC - 1)) ? INIT : POR_WAIT;
      INIT: begin
        state_n = SETUP;
        rs_n = 1'b0;
        data_n = step == 2'd0 ? 8'h38 : step == 2'd1 ? 8'h0C : step == 2'd2 ? 8'h01 : 8'h06;
      end
      IDLE: if (slot_full) begin
        state_n = SETUP;
        rs_n = slot_rs;
        data_n = slot_data;
      end
      SETUP:   state_n = (cnt == CW'(SETUP_CYC - 1)) ? EN_HIGH : SETUP;
      EN_HIGH: state_n = (cnt == CW'(EN_CYC - 1)) ? HOLD : EN_HIGH;
      HOLD:    state_n = (cnt == CW'(HOLD_CYC - 1)) ? WAIT : HOLD;
      WAIT: if (cnt == (clr ? CW'(CLR_CYC - 1) : CW'(EXEC_CYC - 1))) begin
        // Init steps chain back through INIT until the fourth command's wait expires
        state_n = (init_done_o || step == 2'd3) ? IDLE : INIT;
        done_n = init_done_o || step == 2'd3;
        step_n = init_done_o ? step : step + 2'd1;
      end
      default: state_n = POR_WAIT;
    endcase
    cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
    slot_full_n = new_cmd || (slot_full && !pop);
    slot_rs_n = new_cmd ? io_lcd_i[8] : slot_rs;
    slot_data_n = new_cmd ? io_lcd_i[7:0] : slot_data;
    ovf_n = ovf_o || (new_cmd && slot_full && !pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= POR_WAIT;
      cnt <= '0;
      step <= 2'd0;
      init_done_o <= 1'b0;
      lcd_rs_o <= 1'b0;
      lcd_data_o <= 8'h00;
      lcd_en_o <= 1'b0;
      lcd_on_o <= 1'b0;
      busy_o <= 1'b1;
      ovf_o <= 1'b0;
      slot_full <= 1'b0;
      slot_rs <= 1'b0;
      slot_data <= 8'h00;
      last_tog <= io_lcd_i[30];
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      step <= step_n;
      init_done_o <= done_n;
      lcd_rs_o <= rs_n;
      lcd_data_o <= data_n;
      lcd_en_o <= state_n == EN_HIGH;
      lcd_on_o <= io_lcd_i[31];
      busy_o <= state_n != IDLE || slot_full_n;
      ovf_o <= ovf_n;
      slot_full <= slot_full_n;
      slot_rs <= slot_rs_n;
      slot_data <= slot_data_n;
      last_tog <= io_lcd_i[30];
    end
  end
endmodule

// File: tb/tb_lcd_cmd_driver.sv
// tb_lcd_cmd_driver: directed checks of init sequence, write timing, pending slot and reset abort.
module tb_lcd_cmd_driver;
  localparam int POR = 10, SU = 2, EN = 4, HO = 2, EX = 20, CL = 50;

  logic clk = 1'b0, rst = 1'b1, tog = 1'b0;
  logic [31:0] io;
  logic lcd_on, lcd_rs, lcd_rw, lcd_en, busy, init_done, ovf;
  logic [7:0] lcd_data;

  lcd_cmd_driver #(.POR_CYC(POR), .SETUP_CYC(SU), .EN_CYC(EN), .HOLD_CYC(HO),
                   .EXEC_CYC(EX), .CLR_CYC(CL)) dut (
    .clk_i(clk), .rst_i(rst), .io_lcd_i(io), .lcd_on_o(lcd_on), .lcd_rs_o(lcd_rs),
    .lcd_rw_o(lcd_rw), .lcd_en_o(lcd_en), .lcd_data_o(lcd_data), .busy_o(busy),
    .init_done_o(init_done), .ovf_o(ovf));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {logic rs; logic [7:0] d; int rise; int fall; int stab;} pulse_t;
  pulse_t q[$];
  pulse_t cur;
  logic en_q = 1'b0;
  logic [8:0] bus_q = 9'd0;
  int stab = 0;

  // Each EN pulse is logged with its bus value, edge times and how long the bus was stable at the rise
  always @(negedge clk) begin
    stab = ({lcd_rs, lcd_data} == bus_q) ? stab + 1 : 1;
    if (lcd_en && !en_q) begin
      cur.rs = lcd_rs; cur.d = lcd_data; cur.rise = cyc; cur.stab = stab;
    end
    if (lcd_en && en_q && {lcd_rs, lcd_data} != bus_q) cur.stab = 0;
    if (!lcd_en && en_q) begin
      cur.fall = cyc;
      q.push_back(cur);
    end
    bus_q = {lcd_rs, lcd_data};
    en_q = lcd_en;
  end

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_pulse(output pulse_t p);
    int k = 0;
    while (q.size() == 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (q.size() == 0) begin
      check("pulse_timeout", q.size(), 1);
      p = '{rs: 1'b0, d: 8'h00, rise: 0, fall: 0, stab: 0};
    end else p = q.pop_front();
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_busy(output int b);
    b = 0;
    while (busy && b < 500) begin
      b++;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int n);
    tog = ~tog;
    io = {1'b1, tog, 21'd0, rs, d};
    n = cyc + 1;
  endtask

  task automatic init_seq(input int c0);
    logic [7:0] exp_d[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int gap[3] = '{25, 25, 55};
    pulse_t p, pp;
    pp = '{rs: 1'b0, d: 8'h00, rise: 0, fall: 0, stab: 0};
    for (int i = 0; i < 4; i++) begin
      get_pulse(p);
      check($sformatf("init%0d_data", i), p.d, exp_d[i]);
      check($sformatf("init%0d_rs", i), p.rs, 0);
      check($sformatf("init%0d_width", i), p.fall - p.rise, EN);
      if (i == 0) check("init_first_rise", p.rise - c0, 13);
      else check($sformatf("init%0d_gap", i), p.rise - pp.fall, gap[i-1]);
      pp = p;
    end
    wait_cyc(pp.fall + 21);
    check("init_done_early", init_done, 0);
    check("busy_before_done", busy, 1);
    wait_cyc(pp.fall + 22);
    check("init_done", init_done, 1);
    check("busy_after_init", busy, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    pulse_t p, p2, p3;
    int n, b, c0;
    io = 32'h0000_0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_data", lcd_data, 0);
    check("rst_on", lcd_on, 0);
    check("rst_busy", busy, 1);
    check("rst_done", init_done, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    c0 = cyc;
    init_seq(c0);

    send(1'b1, 8'h41, n);
    check("on_before", lcd_on, 0);
    @(negedge clk);
    check("on_after", lcd_on, 1);
    wait_busy(b);
    check("busy_len_A", b, 29);
    get_pulse(p);
    check("A_rs", p.rs, 1);
    check("A_data", p.d, 8'h41);
    check("A_width", p.fall - p.rise, EN);
    check("A_rise", p.rise - n, 3);
    check("A_setup_stable", p.stab >= 3, 1);

    send(1'b0, 8'h01, n);
    @(negedge clk);
    wait_busy(b);
    check("busy_len_clear", b, 59);
    get_pulse(p);
    check("clear_data", p.d, 8'h01);
    check("clear_rs", p.rs, 0);

    send(1'b0, 8'h04, n);
    @(negedge clk);
    wait_busy(b);
    check("busy_len_0x04", b, 29);
    get_pulse(p);
    check("0x04_data", p.d, 8'h04);

    send(1'b1, 8'h58, n);
    wait_cyc(n + 4);
    send(1'b1, 8'h59, b);
    wait_cyc(n + 29);
    send(1'b1, 8'h5A, b);
    get_pulse(p);
    get_pulse(p2);
    get_pulse(p3);
    check("pop_X", p.d, 8'h58);
    check("pop_Y", p2.d, 8'h59);
    check("pop_Z", p3.d, 8'h5A);
    check("pop_gap_XY", p2.rise - p.fall, 25);
    check("pop_gap_YZ", p3.rise - p2.fall, 25);
    wait_busy(b);
    check("pop_ovf", ovf, 0);
    check("pop_no_extra", q.size(), 0);

    send(1'b1, 8'h41, n);
    wait_cyc(n + 3);
    send(1'b1, 8'h42, b);
    wait_cyc(n + 5);
    check("ovf_before", ovf, 0);
    send(1'b1, 8'h43, b);
    @(negedge clk);
    check("ovf_set", ovf, 1);
    get_pulse(p);
    get_pulse(p2);
    check("ovf_first", p.d, 8'h41);
    check("ovf_last", p2.d, 8'h43);
    wait_busy(b);
    repeat (40) @(negedge clk);
    check("ovf_no_B", q.size(), 0);
    check("ovf_sticky", ovf, 1);

    send(1'b1, 8'h57, n);
    wait_cyc(n + 4);
    check("abort_en_high", lcd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_en_low", lcd_en, 0);
    check("abort_busy", busy, 1);
    check("abort_done", init_done, 0);
    check("abort_ovf", ovf, 0);
    check("abort_on", lcd_on, 0);
    tog = ~tog;
    io = {1'b1, tog, 30'd0};
    repeat (2) @(negedge clk);
    q.delete();
    rst = 1'b0;
    c0 = cyc;
    init_seq(c0);
    repeat (40) @(negedge clk);
    check("release_no_cmd", q.size(), 0);
    check("release_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
